imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
- Inverse of the immediate extender: takes a base instruction word plus a 32-bit immediate and an immediate-type selector, and scatters the immediate into the type-specific bit positions of the instruction word.
- Used by the instruction-memory loader and by self-check benches to build program images.
- Streams instructions through a valid/ready pipeline stage.
- A sequencer counts words, generates the word-aligned memory address, and signals completion of a program block.

Parameters:
- WIDTH, 32, instruction/immediate width; only 32 is supported.
- PROG_WORDS, 16, number of instructions per program block; must be 1..2^(ADDR_W-2).
- ADDR_W, 10, byte-address width of out_addr.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a program block (honoured in IDLE only).
- in_valid  in  1  input word valid.
- in_ready  out  1  encoder can accept an input word.
- selector  in  3  immediate type: 0 = I, 1 = S, 2 = SB, 3 = U, 4..7 = illegal.
- base  in  WIDTH  template instruction; non-immediate fields (opcode, rd, funct3, rs1, rs2, funct7).
- imm  in  WIDTH  full-width signed immediate value.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  downstream accepts the word.
- out_instr  out  WIDTH  encoded instruction.
- out_addr  out  ADDR_W  byte address of out_instr (word index × 4).
- out_err  out  1  immediate not representable for the selected type (see Optional Feature).
- done  out  1  one-cycle pulse after the last word of the block is accepted downstream.

Behaviour:
- Reset (synchronous, rst = 1 on a clock edge): state = IDLE; out_valid = 0, out_instr = 0, out_addr = 0, out_err = 0, done = 0; word counter = 0.
- Bit mapping. Every bit not listed below is copied from base.
  - I: instr[31:20] = imm[11:0].
  - S: instr[31:25] = imm[11:5]; instr[11:7] = imm[4:0].
  - SB: instr[31] = imm[12]; instr[30:25] = imm[10:5]; instr[11:8] = imm[4:1]; instr[7] = imm[11]. imm[0] is dropped.
  - U: instr[31:12] = imm[31:12].
  - Illegal selector (4..7): instr = base unchanged.
- FSM states:
  - IDLE: in_ready = 0; done = 0. Moves to LOAD on start.
  - LOAD: in_ready = !out_valid || out_ready. An input transfer occurs when in_valid && in_ready. Moves to DONE when the output handshake of word PROG_WORDS-1 occurs.
  - DONE: done = 1 for exactly one cycle; in_ready = 0. Always moves to IDLE.
  - start is ignored outside IDLE.
- Pipeline:
  - Single registered stage; latency is 1 cycle from input transfer to out_valid.
  - out_instr, out_addr and out_err are stable while out_valid && !out_ready.
  - A simultaneous input transfer and output handshake in the same cycle is allowed; full throughput is 1 word/clk.
  - out_valid clears on an output handshake with no new input transfer.
- Address:
  - out_addr = counter × 4, captured at input transfer.
  - The counter increments on each input transfer and clears on entry to LOAD.
  - The counter never exceeds PROG_WORDS-1 because input is blocked after word PROG_WORDS-1 is accepted.
- rst asserted mid-block: all outputs return to reset values on that edge; the in-flight word is discarded; no done pulse is generated.
- selector and imm are sampled only at input transfer; changes at other times have no effect.

Optional Feature:
- Macro: IMM_RANGE_CHECK_EN.
- Defined: out_err is registered alongside out_instr. out_err = 1 when:
  - I or S: imm is not within -2048..2047.
  - SB: imm is not within -4096..4094, or imm[0] = 1.
  - U: imm[11:0] != 0.
  - selector = 4..7.
  - An erroneous word is still emitted, encoded with truncation, and still counted.
- Not defined: out_err is tied to 0; out-of-range immediates are silently truncated per the bit mapping; no range-check logic is synthesised.

Test Plan:
- start, then I, base = 0x00000013, imm = 0xFFFFFFFF, out_ready = 1 -> next cycle out_valid = 1, out_instr = 0xFFF00013, out_addr = 0x000, out_err = 0.
- S, base = 0x0020A023, imm = 8 -> out_instr = 0x0020A423. SB, base = 0x00000063, imm = -4 -> out_instr = 0xFE000EE3. U, base = 0x000002B7, imm = 0x12345000 -> out_instr = 0x123452B7.
- With IMM_RANGE_CHECK_EN defined: SB imm = 3 -> out_err = 1; I imm = 2048 -> out_err = 1, out_instr[31:20] = 0x800; U imm = 0x12345001 -> out_err = 1. Without the macro, the same stimulus gives out_err = 0.
- Backpressure: hold out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0 and out_instr/out_addr stable; release -> 1 word/clk resumes with addresses 0x004, 0x008, … in order.
- PROG_WORDS = 4, stream 4 words -> out_addr runs 0x000..0x00C; done pulses for exactly one cycle after the 4th output handshake; in_ready = 0 until the next start.
- Assert rst for one cycle after the 2nd input transfer -> out_valid = 0, state IDLE, no done pulse; a new start restarts out_addr at 0x000.

Source files
------------

// File: rtl/imm_encoder.sv
// Purpose : scatters a 32-bit immediate into the type-specific fields of a base
//           instruction word (I/S/SB/U) and streams a program block with addresses.
// Latency : 1 cycle from input transfer to out_valid; 1 word/clk sustained.
// Backpressure: in_ready drops while out_valid && !out_ready; outputs hold while stalled.
//
// Ports   : clk/rst (sync, active-high); start pulse opens a block of PROG_WORDS words;
//           in_valid/in_ready + selector/base/imm in; out_valid/out_ready + out_instr,
//           out_addr (word index * 4), out_err out; done pulses once per block.
// Option  : define IMM_RANGE_CHECK_EN to flag immediates not representable in the
//           selected format on out_err (otherwise out_err is tied low).
module imm_encoder #(
    parameter int WIDTH      = 32,
    parameter int PROG_WORDS = 16,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        selector,
    input  logic [WIDTH-1:0]  base,
    input  logic [WIDTH-1:0]  imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic              done
);

    localparam int CNT_W = ADDR_W - 2;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PROG_WORDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // Set once the last word of the block has been accepted; blocks further input.
    logic              all_in_q, all_in_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_instr_q, out_instr_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    // Marks that the word in the output register is the block's final word.
    logic              out_last_q, out_last_d;

    logic              in_xfer;
    logic              out_hs;
    logic [WIDTH-1:0]  enc_instr;

    // Immediate scatter: only the immediate fields are overwritten, the rest of base passes.
    always_comb begin
        enc_instr = base;
        case (selector)
            3'd0: enc_instr[31:20] = imm[11:0];
            3'd1: begin
                enc_instr[31:25] = imm[11:5];
                enc_instr[11:7]  = imm[4:0];
            end
            3'd2: begin
                enc_instr[31]    = imm[12];
                enc_instr[30:25] = imm[10:5];
                enc_instr[11:8]  = imm[4:1];
                enc_instr[7]     = imm[11];
            end
            3'd3: enc_instr[31:12] = imm[31:12];
            default: enc_instr = base;
        endcase
    end

    assign in_ready = (state_q == S_LOAD) && !all_in_q && (!out_valid_q || out_ready);
    assign in_xfer  = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        all_in_d    = all_in_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_LOAD;
                    cnt_d    = '0;
                    all_in_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (in_xfer) begin
                    // Counter parks on the last index; all_in stops further input.
                    if (cnt_q == LAST_IDX) begin
                        all_in_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (out_hs && out_last_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (in_xfer) begin
            out_valid_d = 1'b1;
            out_instr_d = enc_instr;
            out_addr_d  = {cnt_q, 2'b00};
            out_last_d  = (cnt_q == LAST_IDX);
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            all_in_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            all_in_q    <= all_in_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
        end
    end

`ifdef IMM_RANGE_CHECK_EN
    logic err_calc;
    logic out_err_q, out_err_d;

    // Representable iff the bits above the field's sign bit are a pure sign extension.
    always_comb begin
        err_calc = 1'b1;
        case (selector)
            3'd0, 3'd1: err_calc = !((&imm[31:11]) || !(|imm[31:11]));
            3'd2:       err_calc = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            3'd3:       err_calc = |imm[11:0];
            default:    err_calc = 1'b1;
        endcase
    end

    always_comb begin
        out_err_d = out_err_q;
        if (in_xfer) begin
            out_err_d = err_calc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_err_q <= 1'b0;
        end else begin
            out_err_q <= out_err_d;
        end
    end

    assign out_err = out_err_q;
`else
    assign out_err = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_addr  = out_addr_q;
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_imm_encoder.sv
module tb_imm_encoder;

    localparam int PW = 4;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_ready, out_valid, out_ready, out_err, done;
    logic [2:0]  selector;
    logic [31:0] base, imm, out_instr;
    logic [9:0]  out_addr;

    imm_encoder #(.WIDTH(32), .PROG_WORDS(PW), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .selector(selector), .base(base), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
        .done(done)
    );

    always #5 clk = ~clk;

`ifdef IMM_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder written as mask-and-shift arithmetic on the format tables.
    function automatic logic [31:0] m_enc(input int sel, input logic [31:0] b, input logic [31:0] i);
        case (sel)
            0: return (b & 32'h000F_FFFF) | ((i & 32'hFFF) << 20);
            1: return (b & 32'h01FF_F07F) | (((i >> 5) & 32'h7F) << 25) | ((i & 32'h1F) << 7);
            2: return (b & 32'h01FF_F07F) | (((i >> 12) & 32'h1) << 31) |
                      (((i >> 5) & 32'h3F) << 25) | (((i >> 1) & 32'hF) << 8) |
                      (((i >> 11) & 32'h1) << 7);
            3: return (b & 32'h0000_0FFF) | (i & 32'hFFFF_F000);
            default: return b;
        endcase
    endfunction

    function automatic logic m_err(input int sel, input logic [31:0] i);
        int si;
        si = $signed(i);
        if (!RC) return 1'b0;
        case (sel)
            0, 1: return (si < -2048) || (si > 2047);
            2:    return (si < -4096) || (si > 4094) || i[0];
            3:    return (i & 32'hFFF) != 0;
            default: return 1'b1;
        endcase
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [9:0]  addr;
        logic        err;
    } item_t;

    item_t       q[$];
    logic [31:0] log_instr[$];
    logic [9:0]  log_addr[$];
    logic        log_err[$];
    int          phase  = 0;   // 0 idle, 1 loading, 2 done
    int          taken  = 0;
    int          done_cnt = 0;
    logic        mon_en = 1'b0;

    // Per-cycle compare against the model; decisions at negedge describe the next posedge.
    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_rdy, last_hs;
            exp_rdy = (phase == 1) && (taken < PW) && ((q.size() == 0) || out_ready);
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
            chk("done", {31'd0, done}, {31'd0, phase == 2});
            if (q.size() != 0) begin
                chk("out_instr", out_instr, q[0].instr);
                chk("out_addr", {22'd0, out_addr}, {22'd0, q[0].addr});
                chk("out_err", {31'd0, out_err}, {31'd0, q[0].err});
            end
            if (done) done_cnt++;
            if (rst) begin
                q.delete();
                phase = 0;
                taken = 0;
            end else begin
                last_hs = 1'b0;
                if (q.size() != 0 && out_ready) begin
                    log_instr.push_back(out_instr);
                    log_addr.push_back(out_addr);
                    log_err.push_back(out_err);
                    if (q[0].addr == 10'((PW - 1) * 4)) last_hs = 1'b1;
                    void'(q.pop_front());
                end
                if (in_valid && exp_rdy) begin
                    q.push_back('{m_enc(int'(selector), base, imm), 10'(taken * 4),
                                  m_err(int'(selector), imm)});
                    taken++;
                end
                case (phase)
                    0: if (start) begin phase = 1; taken = 0; end
                    1: if (last_hs) phase = 2;
                    default: phase = 0;
                endcase
            end
        end
    end

    task automatic send(input logic [2:0] s, input logic [31:0] b, input logic [31:0] i);
        int n;
        selector = s; base = b; imm = i; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        selector = 3'd7; imm = 32'hDEAD_BEEF; base = 32'h5A5A_5A5A;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 40) begin
            @(posedge clk); #2;
            n++;
        end
        chk("done_seen", done_cnt, target);
    endtask

    task automatic clear_log();
        log_instr.delete(); log_addr.delete(); log_err.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        selector = 3'd0; base = '0; imm = '0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_addr", {22'd0, out_addr}, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;

        // Block A: one word of each format, full throughput; a stray start is ignored.
        clear_log();
        @(posedge clk); #1;
        pulse_start();
        send(3'd0, 32'h0000_0013, 32'hFFFF_FFFF);
        #1;
        chk("A_first_valid", {31'd0, out_valid}, 32'd1);
        chk("A_first_instr", out_instr, 32'hFFF0_0013);
        chk("A_first_addr", {22'd0, out_addr}, 32'd0);
        chk("A_first_err", {31'd0, out_err}, 32'd0);
        start = 1'b1;
        send(3'd1, 32'h0020_A023, 32'd8);
        start = 1'b0;
        send(3'd2, 32'h0000_0063, -32'sd4);
        send(3'd3, 32'h0000_02B7, 32'h1234_5000);
        wait_done(1);
        chk("A_log_size", log_instr.size(), 32'd4);
        if (log_instr.size() == 4) begin
            chk("A_S_instr", log_instr[1], 32'h0020_A423);
            chk("A_SB_instr", log_instr[2], 32'hFE00_0EE3);
            chk("A_U_instr", log_instr[3], 32'h1234_52B7);
            chk("A_addr3", {22'd0, log_addr[3]}, 32'h00C);
        end
        repeat (3) @(posedge clk);
        #2;
        chk("A_done_once", done_cnt, 32'd1);
        chk("A_idle_in_ready", {31'd0, in_ready}, 32'd0);

        // Block B: range-check cases.
        clear_log();
        pulse_start();
        send(3'd2, 32'h0000_0063, 32'd3);
        send(3'd0, 32'h0000_0013, 32'd2048);
        send(3'd3, 32'h0000_02B7, 32'h1234_5001);
        send(3'd0, 32'h0000_0013, 32'd5);
        wait_done(2);
        if (log_instr.size() == 4) begin
            chk("B_SB_odd_instr", log_instr[0], 32'h0000_0163);
            chk("B_SB_odd_err", {31'd0, log_err[0]}, {31'd0, RC});
            chk("B_I_2048_field", {20'd0, log_instr[1][31:20]}, 32'h800);
            chk("B_I_2048_err", {31'd0, log_err[1]}, {31'd0, RC});
            chk("B_U_low_err", {31'd0, log_err[2]}, {31'd0, RC});
            chk("B_I_ok_err", {31'd0, log_err[3]}, 32'd0);
        end else begin
            chk("B_log_size", log_instr.size(), 32'd4);
        end

        // Block C: backpressure for three cycles with input pending.
        clear_log();
        @(posedge clk); #1;
        pulse_start();
        out_ready = 1'b0;
        send(3'd0, 32'h0000_0013, 32'd1);
        selector = 3'd0; base = 32'h0000_0013; imm = 32'd2; in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #2;
            chk("C_stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("C_stall_instr", out_instr, 32'h0010_0013);
            chk("C_stall_addr", {22'd0, out_addr}, 32'd0);
        end
        out_ready = 1'b1;
        send(3'd0, 32'h0000_0013, 32'd2);
        send(3'd0, 32'h0000_0013, 32'd3);
        send(3'd0, 32'h0000_0013, 32'd4);
        wait_done(3);
        chk("C_log_size", log_addr.size(), 32'd4);
        for (int k = 0; k < 4 && k < log_addr.size(); k++)
            chk("C_addr_seq", {22'd0, log_addr[k]}, 32'(k * 4));

        // Block D: reset after the second input transfer.
        @(posedge clk); #1;
        pulse_start();
        send(3'd0, 32'h0000_0013, 32'd7);
        send(3'd0, 32'h0000_0013, 32'd8);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("D_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("D_rst_in_ready", {31'd0, in_ready}, 32'd0);
        dc = done_cnt;
        repeat (5) @(posedge clk);
        #2;
        chk("D_no_done", done_cnt, dc);
        clear_log();
        pulse_start();
        send(3'd1, 32'h0000_0023, 32'd1);
        send(3'd1, 32'h0000_0023, 32'd2);
        send(3'd1, 32'h0000_0023, 32'd3);
        send(3'd1, 32'h0000_0023, 32'd4);
        wait_done(dc + 1);
        chk("D_restart_size", log_addr.size(), 32'd4);
        if (log_addr.size() != 0)
            chk("D_restart_addr0", {22'd0, log_addr[0]}, 32'd0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
